vector_frame_accumulator: RTL

Downstream neighbour of the input buffer: consumes the buffer's dequeued vector stream (valid, eof, N lanes) and reduces every frame (vectors up to and including the one flagged eof) to a single N-lane vector using a runtime-configured element-wise operation. It emits one result vector per frame plus the frame length, or forwards vectors unchanged in pass-through mode. It is the first reduction stage of the trace pipeline.

---
 rtl/vector_frame_accumulator.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/vector_frame_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : vector_frame_accumulator
//  Description : Reduces each eof-delimited frame of N-lane signed vectors to
//                one result vector using a runtime-selected element-wise op
//                (PASS / saturating SUM / signed MAX / signed MIN) and reports
//                the frame length alongside the registered result.
//  Revision    : 1.0 - initial release
// ============================================================================
module vector_frame_accumulator #(
  parameter int         N          = 8,
  parameter int         DATA_WIDTH = 32,
  parameter logic [7:0] CONFIG_ID  = 8'd3,
  parameter int         LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tracing,
  input  logic [7:0]            configId,
  input  logic [7:0]            configData,
  input  logic                  valid_in,
  input  logic                  eof_in,
  input  logic [DATA_WIDTH-1:0] vector_in [N-1:0],
  output logic                  valid_out,
  output logic                  eof_out,
  output logic [DATA_WIDTH-1:0] vector_out [N-1:0],
  output logic [LEN_WIDTH-1:0]  frame_len_out,
  output logic                  busy_out
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_t;

  localparam logic [1:0] OP_PASS = 2'd0;
  localparam logic [1:0] OP_SUM  = 2'd1;
  localparam logic [1:0] OP_MAX  = 2'd2;
  localparam logic [1:0] OP_MIN  = 2'd3;

  // Source of an emitted result vector
  localparam logic [1:0] SRC_IN  = 2'd0;
  localparam logic [1:0] SRC_OP  = 2'd1;
  localparam logic [1:0] SRC_ACC = 2'd2;

  // Accumulator update selection
  localparam logic [1:0] ACC_HOLD    = 2'd0;
  localparam logic [1:0] ACC_LOAD_IN = 2'd1;
  localparam logic [1:0] ACC_LOAD_OP = 2'd2;

  localparam logic [LEN_WIDTH-1:0]  LEN_MAX = {LEN_WIDTH{1'b1}};
  localparam logic [LEN_WIDTH-1:0]  LEN_ONE = LEN_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] SAT_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SAT_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  state_t                r_state;
  state_t                w_state_nxt;
  logic [1:0]            r_pending_op;
  logic [1:0]            r_active_op;
  logic [DATA_WIDTH-1:0] r_acc [N-1:0];
  logic [LEN_WIDTH-1:0]  r_len;

  logic                  w_v;
  logic                  w_e;
  logic                  w_cfg_hit;
  logic [1:0]            w_pending_fwd;
  logic [LEN_WIDTH-1:0]  w_len_inc;
  logic [LEN_WIDTH-1:0]  w_len_nxt;
  logic [1:0]            w_acc_sel;
  logic                  w_emit;
  logic                  w_emit_eof;
  logic [LEN_WIDTH-1:0]  w_emit_len;
  logic [1:0]            w_emit_src;
  logic                  w_copy_op;
  logic [DATA_WIDTH-1:0] w_op_res   [N-1:0];
  logic [DATA_WIDTH-1:0] w_emit_vec [N-1:0];
  logic                  w_unused_cfg;

  // tracing=0 masks the stream completely; the frame state simply waits
  assign w_v = valid_in & tracing;
  assign w_e = eof_in & tracing;

  assign w_cfg_hit    = (configId == CONFIG_ID);
  assign w_unused_cfg = ^configData[7:2];

  // A write in the same cycle as an op handover is forwarded so that an idle
  // block picks up the new op on the very next cycle.
  assign w_pending_fwd = w_cfg_hit ? configData[1:0] : r_pending_op;

  // Frame length sticks at its maximum while accumulation carries on
  assign w_len_inc = (r_len == LEN_MAX) ? r_len : r_len + LEN_ONE;

  assign busy_out = (r_state == ST_ACCUM);

  generate
    for (genvar i = 0; i < N; i++) begin : g_lane
      logic [DATA_WIDTH:0]   w_sum_ext;
      logic                  w_acc_gt_in;
      logic [DATA_WIDTH-1:0] w_lane_res;

      assign w_sum_ext   = {r_acc[i][DATA_WIDTH-1], r_acc[i]}
                         + {vector_in[i][DATA_WIDTH-1], vector_in[i]};
      assign w_acc_gt_in = ($signed(r_acc[i]) > $signed(vector_in[i]));

      // Per-lane combine of accumulator with incoming element
      always_comb begin
        w_lane_res = vector_in[i];
        case (r_active_op)
          OP_SUM: begin
            if (w_sum_ext[DATA_WIDTH] != w_sum_ext[DATA_WIDTH-1]) begin
              w_lane_res = w_sum_ext[DATA_WIDTH] ? SAT_NEG : SAT_POS;
            end else begin
              w_lane_res = w_sum_ext[DATA_WIDTH-1:0];
            end
          end
          OP_MAX:  w_lane_res = w_acc_gt_in ? r_acc[i] : vector_in[i];
          OP_MIN:  w_lane_res = w_acc_gt_in ? vector_in[i] : r_acc[i];
          default: w_lane_res = vector_in[i];
        endcase
      end

      assign w_op_res[i]   = w_lane_res;
      assign w_emit_vec[i] = (w_emit_src == SRC_OP)  ? w_lane_res :
                             (w_emit_src == SRC_ACC) ? r_acc[i]   :
                                                       vector_in[i];
    end
  endgenerate

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode plus datapath controls for accumulate / emit / op handover
  always_comb begin
    w_state_nxt = r_state;
    w_len_nxt   = r_len;
    w_acc_sel   = ACC_HOLD;
    w_emit      = 1'b0;
    w_emit_eof  = 1'b0;
    w_emit_len  = r_len;
    w_emit_src  = SRC_IN;
    w_copy_op   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Idle cycles hand the pending op over unless a multi-vector frame opens
        w_copy_op = 1'b1;
        if (w_v) begin
          if ((r_active_op == OP_PASS) || w_e) begin
            // PASS vectors and single-vector frames go straight out
            w_emit     = 1'b1;
            w_emit_eof = w_e;
            w_emit_len = LEN_ONE;
            w_emit_src = SRC_IN;
            w_len_nxt  = LEN_ONE;
          end else begin
            w_state_nxt = ST_ACCUM;
            w_acc_sel   = ACC_LOAD_IN;
            w_len_nxt   = LEN_ONE;
            w_copy_op   = 1'b0;
          end
        end
      end
      ST_ACCUM: begin
        if (w_v) begin
          w_acc_sel = ACC_LOAD_OP;
          w_len_nxt = w_len_inc;
          if (w_e) begin
            w_emit      = 1'b1;
            w_emit_eof  = 1'b1;
            w_emit_len  = w_len_inc;
            w_emit_src  = SRC_OP;
            w_state_nxt = ST_IDLE;
            w_copy_op   = 1'b1;
          end
        end else if (w_e) begin
          // eof without data closes the frame with what has been gathered
          w_emit      = 1'b1;
          w_emit_eof  = 1'b1;
          w_emit_len  = r_len;
          w_emit_src  = SRC_ACC;
          w_state_nxt = ST_IDLE;
          w_copy_op   = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Config registers, accumulator, length counter and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending_op  <= OP_PASS;
      r_active_op   <= OP_PASS;
      r_len         <= '0;
      valid_out     <= 1'b0;
      eof_out       <= 1'b0;
      frame_len_out <= '0;
      for (int i = 0; i < N; i++) begin
        r_acc[i]      <= '0;
        vector_out[i] <= '0;
      end
    end else begin
      if (w_cfg_hit) begin
        r_pending_op <= configData[1:0];
      end
      if (w_copy_op) begin
        r_active_op <= w_pending_fwd;
      end
      r_len     <= w_len_nxt;
      valid_out <= w_emit;
      eof_out   <= w_emit_eof;
      if (w_emit) begin
        frame_len_out <= w_emit_len;
      end
      for (int i = 0; i < N; i++) begin
        case (w_acc_sel)
          ACC_LOAD_IN: r_acc[i] <= vector_in[i];
          ACC_LOAD_OP: r_acc[i] <= w_op_res[i];
          default:     r_acc[i] <= r_acc[i];
        endcase
        if (w_emit) begin
          vector_out[i] <= w_emit_vec[i];
        end
      end
    end
  end

endmodule
`default_nettype wire
